pc_predict: RTL and testbench

- Parametrised fetch-stage program counter with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Produces the fetch PC each cycle and predicts the next PC; execute-stage resolution corrects it via a redirect port and trains the BTB via an update port.
- Sits between hazard unit / execute stage and the instruction-memory request path.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/pc_predict_if.sv | 28 ++
 rtl/pc_predict_btb_table.sv | 67 ++++++
 rtl/pc_predict.sv | 54 +++++
 tb/tb_pc_predict.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, branch-direction counter encoding and its training rule.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [1:0]  btb_ctr_t;

    localparam btb_ctr_t CTR_SNT = 2'b00;
    localparam btb_ctr_t CTR_WNT = 2'b01;
    localparam btb_ctr_t CTR_WT  = 2'b10;
    localparam btb_ctr_t CTR_ST  = 2'b11;

    // Saturating two-bit counter step; the MSB is the predicted direction.
    function automatic btb_ctr_t ctr_train(input btb_ctr_t ctr, input logic taken);
        btb_ctr_t res;
        res = ctr;
        if (taken && ctr != CTR_ST)
            res = ctr + 2'd1;
        else if (!taken && ctr != CTR_SNT)
            res = ctr - 2'd1;
        return res;
    endfunction

endpackage

// File: rtl/pc_predict_if.sv
// Fetch-PC bundle: stall/redirect and training inputs from hazard/execute, fetch PC and prediction out.
interface pc_predict_if #(parameter int WORD_W = 32);

    logic              pcen;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic              upd_valid;
    logic [WORD_W-1:0] upd_pc;
    logic [WORD_W-1:0] upd_target;
    logic              upd_taken;
    logic [WORD_W-1:0] pcout;
    logic [WORD_W-1:0] pcplus4;
    logic              pred_taken;
    logic [WORD_W-1:0] pred_target;

    modport master (
        output pcen, redirect_valid, redirect_pc,
        output upd_valid, upd_pc, upd_target, upd_taken,
        input  pcout, pcplus4, pred_taken, pred_target
    );

    modport slave (
        input  pcen, redirect_valid, redirect_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken,
        output pcout, pcplus4, pred_taken, pred_target
    );

endinterface

// File: rtl/pc_predict_btb_table.sv
// Direct-mapped BTB: combinational lookup, single training port written at the clock edge.
// A lookup and an update to the same entry in one cycle sees the old contents.
module btb_table
    import cpu_types_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] lookup_pc,
    output logic              lookup_taken,
    output logic [WORD_W-1:0] lookup_target,
    input  logic              upd_valid,
    input  logic [WORD_W-1:0] upd_pc,
    input  logic [WORD_W-1:0] upd_target,
    input  logic              upd_taken
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    // Targets are word aligned, so only the upper bits are kept.
    logic              valid_q  [BTB_DEPTH];
    logic [TAG_W-1:0]  tag_q    [BTB_DEPTH];
    logic [WORD_W-3:0] target_q [BTB_DEPTH];
    btb_ctr_t          ctr_q    [BTB_DEPTH];

    logic [IDX_W-1:0] lidx, uidx;
    logic [TAG_W-1:0] ltag, utag;
    logic             lhit, uhit;

    assign lidx = lookup_pc[IDX_W+1:2];
    assign ltag = lookup_pc[WORD_W-1:IDX_W+2];
    assign uidx = upd_pc[IDX_W+1:2];
    assign utag = upd_pc[WORD_W-1:IDX_W+2];

    assign lhit = valid_q[lidx] && (tag_q[lidx] == ltag);
    assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

    assign lookup_taken  = lhit && ctr_q[lidx][1];
    assign lookup_target = lookup_taken ? {target_q[lidx], 2'b00} : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_SNT;
            end
        end else if (upd_valid) begin
            if (uhit) begin
                ctr_q[uidx] <= ctr_train(ctr_q[uidx], upd_taken);
                if (upd_taken)
                    target_q[uidx] <= upd_target[WORD_W-1:2];
            end else if (upd_taken) begin
                // Not-taken misses are not worth an entry; taken ones start weakly taken.
                valid_q[uidx]  <= 1'b1;
                tag_q[uidx]    <= utag;
                target_q[uidx] <= upd_target[WORD_W-1:2];
                ctr_q[uidx]    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/pc_predict.sv
// Fetch PC register with BTB-driven next-PC prediction; redirect lands on pcout one cycle later.
// Priority: redirect, then stall (pcen=0 holds), then predicted target, then pc+4.
module pc_predict
    import cpu_types_pkg::*;
#(
    parameter int                WORD_W    = 32,
    parameter logic [WORD_W-1:0] RESET_PC  = '0,
    parameter int                BTB_DEPTH = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    pc_predict_if.slave  bus
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_inc;
    logic              btb_taken;
    logic [WORD_W-1:0] btb_target;

    assign pc_inc          = pc_q + WORD_W'(4);
    assign bus.pcout       = pc_q;
    assign bus.pcplus4     = pc_inc;
    assign bus.pred_taken  = btb_taken;
    assign bus.pred_target = btb_target;

    btb_table #(
        .WORD_W    (WORD_W),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .CLK           (CLK),
        .nRST          (nRST),
        .lookup_pc     (pc_q),
        .lookup_taken  (btb_taken),
        .lookup_target (btb_target),
        .upd_valid     (bus.upd_valid),
        .upd_pc        (bus.upd_pc),
        .upd_target    (bus.upd_target),
        .upd_taken     (bus.upd_taken)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            pc_q <= RESET_PC;
        else if (bus.redirect_valid)
            pc_q <= {bus.redirect_pc[WORD_W-1:2], 2'b00};
        else if (!bus.pcen)
            pc_q <= pc_q;
        else if (btb_taken)
            pc_q <= btb_target;
        else
            pc_q <= pc_inc;
    end

endmodule

// File: tb/tb_pc_predict.sv
// Directed and randomized checks of pc_predict against an array-based predictor model.
module tb_pc_predict;
    import cpu_types_pkg::*;

    localparam word_t RST_PC = 32'h100;
    localparam int    DEPTH  = 16;

    logic CLK = 1'b0;
    logic nRST;
    logic run = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 CLK = ~CLK;

    pc_predict_if #(.WORD_W(32)) bus ();

    pc_predict #(.WORD_W(32), .RESET_PC(RST_PC), .BTB_DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // Model: per-entry valid/tag/target/counter as plain integers.
    word_t mpc;
    bit    mv   [DEPTH];
    word_t mtag [DEPTH];
    word_t mtgt [DEPTH];
    int    mctr [DEPTH];

    function automatic int m_idx(input word_t pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic word_t m_tag(input word_t pc);
        return pc / (4 * DEPTH);
    endfunction

    function automatic bit m_pt(input word_t pc);
        int i;
        i = m_idx(pc);
        return mv[i] && (mtag[i] == m_tag(pc)) && (mctr[i] >= 2);
    endfunction

    function automatic word_t m_tg(input word_t pc);
        return m_pt(pc) ? mtgt[m_idx(pc)] : 32'd0;
    endfunction

    word_t npc;
    int    ui;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mpc = RST_PC;
            for (int i = 0; i < DEPTH; i++) begin
                mv[i] = 1'b0; mtag[i] = '0; mtgt[i] = '0; mctr[i] = 0;
            end
        end else begin
            if (bus.redirect_valid)  npc = bus.redirect_pc & ~32'd3;
            else if (!bus.pcen)      npc = mpc;
            else if (m_pt(mpc))      npc = m_tg(mpc);
            else                     npc = mpc + 32'd4;
            if (bus.upd_valid) begin
                ui = m_idx(bus.upd_pc);
                if (mv[ui] && mtag[ui] == m_tag(bus.upd_pc)) begin
                    if (bus.upd_taken) begin
                        mctr[ui] = (mctr[ui] < 3) ? mctr[ui] + 1 : 3;
                        mtgt[ui] = bus.upd_target & ~32'd3;
                    end else begin
                        mctr[ui] = (mctr[ui] > 0) ? mctr[ui] - 1 : 0;
                    end
                end else if (bus.upd_taken) begin
                    mv[ui] = 1'b1;
                    mtag[ui] = m_tag(bus.upd_pc);
                    mtgt[ui] = bus.upd_target & ~32'd3;
                    mctr[ui] = 2;
                end
            end
            mpc = npc;
        end
    end

    task automatic check(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (run && nRST === 1'b1) begin
            check("pcout", bus.pcout, mpc);
            check("pcplus4", bus.pcplus4, mpc + 32'd4);
            check("pred_taken", word_t'(bus.pred_taken), word_t'(m_pt(mpc)));
            check("pred_target", bus.pred_target, m_tg(mpc));
        end
    end

    task automatic drive(input bit pcen, input bit rv, input word_t rpc,
                         input bit uv, input word_t upc, input word_t utgt, input bit utk);
        bus.pcen = pcen; bus.redirect_valid = rv; bus.redirect_pc = rpc;
        bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_target = utgt; bus.upd_taken = utk;
        @(negedge CLK);
    endtask

    int hyst_exp [5] = '{0, 0, 0, 0, 1};

    initial begin
        nRST = 1'b0;
        bus.pcen = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_pcout", bus.pcout, 32'h100);
        check("rst_pcplus4", bus.pcplus4, 32'h104);
        check("rst_pred_taken", word_t'(bus.pred_taken), 32'd0);
        check("rst_pred_target", bus.pred_target, 32'd0);
        nRST = 1'b1;
        run = 1'b1;

        drive(1, 0, 0, 0, 0, 0, 0);
        check("seq_104", bus.pcout, 32'h104);
        check("seq_104_pt", word_t'(bus.pred_taken), 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("seq_108", bus.pcout, 32'h108);
        check("seq_108_pt", word_t'(bus.pred_taken), 32'd0);
        // Allocate while 108 itself is being looked up: that lookup still misses.
        drive(1, 0, 0, 1, 32'h108, 32'h200, 1);
        check("alloc_rdw_10c", bus.pcout, 32'h10C);
        drive(0, 1, 32'h108, 0, 0, 0, 0);
        check("hit_pt", word_t'(bus.pred_taken), 32'd1);
        check("hit_target", bus.pred_target, 32'h200);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("hit_follow", bus.pcout, 32'h200);

        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 32'h108, 1, 32'h108, 32'h200, k >= 3);
            check($sformatf("hyst_%0d", k), word_t'(bus.pred_taken), word_t'(hyst_exp[k]));
        end

        drive(0, 1, 32'h403, 0, 0, 0, 0);
        check("redirect_align", bus.pcout, 32'h400);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            check($sformatf("stall_%0d", k), bus.pcout, 32'h400);
        end

        drive(0, 1, 32'h148, 0, 0, 0, 0);
        check("alias_pt", word_t'(bus.pred_taken), 32'd0);
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        check("wrap_pcplus4", bus.pcplus4, 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("wrap_pcout", bus.pcout, 32'd0);

        drive(0, 1, 32'h300, 0, 0, 0, 0);
        check("rdw_before", word_t'(bus.pred_taken), 32'd0);
        drive(0, 0, 0, 1, 32'h300, 32'h500, 1);
        check("rdw_after_pt", word_t'(bus.pred_taken), 32'd1);
        check("rdw_after_tgt", bus.pred_target, 32'h500);

        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                nRST = 1'b0;
                bus.upd_valid = 1'b1; bus.upd_pc = 32'h100; bus.upd_target = 32'h80; bus.upd_taken = 1'b1;
                #1;
                check("midrst_pcout", bus.pcout, 32'h100);
                @(posedge CLK);
                #1;
                check("midrst_pt", word_t'(bus.pred_taken), 32'd0);
                @(negedge CLK);
                nRST = 1'b1;
            end
            drive($urandom_range(4, 0) != 0, $urandom_range(7, 0) == 0, word_t'($urandom_range(1023, 0)),
                  $urandom_range(1, 0) == 1, word_t'($urandom_range(1023, 0)) & ~32'd3,
                  word_t'($urandom_range(1023, 0)), $urandom_range(2, 0) != 0);
        end

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
